// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Optional build macro: RX_MAJORITY_EN (3-tap majority sampling).
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int MIN_DIV   = 4;
    localparam int STOP_BITS = 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // Clamp the programmed bit period so the half-period count never underflows.
    function automatic logic [31:0] eff_div(input logic [31:0] div);
        return (div < 32'(MIN_DIV)) ? 32'(MIN_DIV) : div;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the raw rx line, plus an optional 3-tap majority voter.
// Optional build macro: RX_MAJORITY_EN.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_line,
    output logic rx_s,
    output logic vote
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_line};
        end
    end

    assign rx_s = sync_q[1];

`ifdef RX_MAJORITY_EN
    // hist_q holds rx_s from the two previous cycles, so the vote spans mid-1..mid+1.
    logic [1:0] hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign vote = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign vote = rx_s;
`endif

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: oversampled start detection, LSB-first deserialiser, irq/busy/frame-error status.
// Optional build macro: RX_MAJORITY_EN (2-of-3 majority per sample, decision one cycle later).
module uart_rx_frontend
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rx_line,
    input  logic [31:0] i_clk_div,
    input  logic        i_rx_finish,
    output logic [7:0]  o_rx_data,
    output logic        o_irq,
    output logic        o_rx_busy,
    output logic        o_frame_err
);

    rx_state_t   state_q, state_d;
    logic [31:0] div_q;
    logic [31:0] cnt_q;
    logic [31:0] eff;
    logic [31:0] start_load;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        rx_s;
    logic        smp;
    logic        tick;
    logic        start_det;
    logic        shift_en;
    logic        good;
    logic        bad;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .rx_line (i_rx_line),
        .rx_s    (rx_s),
        .vote    (smp)
    );

    assign eff = eff_div(i_clk_div);
`ifdef RX_MAJORITY_EN
    assign start_load = eff >> 1;
`else
    assign start_load = (eff >> 1) - 32'd1;
`endif

    assign tick      = (cnt_q == 32'd0);
    assign o_rx_busy = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        start_det = 1'b0;
        shift_en  = 1'b0;
        good      = 1'b0;
        bad       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d   = START;
                    start_det = 1'b1;
                end
            end
            START: begin
                if (tick) state_d = smp ? IDLE : DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    if (bit_q == 3'(DATA_BITS - 1)) state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    good    = smp;
                    bad     = !smp;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter reloads on every sample; div_q is frozen for the whole frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= 32'd0;
            cnt_q   <= 32'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
        end else begin
            if (start_det) begin
                div_q <= eff;
                cnt_q <= start_load;
                bit_q <= 3'd0;
            end else if (state_q != IDLE) begin
                cnt_q <= tick ? (div_q - 32'd1) : (cnt_q - 32'd1);
            end
            if (shift_en) begin
                shift_q <= {smp, shift_q[7:1]};
                bit_q   <= bit_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rx_data   <= 8'd0;
            o_irq       <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_irq <= good;
            if (good) o_rx_data <= shift_q;
            if (bad) begin
                o_frame_err <= 1'b1;
            end else if (i_rx_finish || start_det) begin
                o_frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend: table of 8N1 frames plus hand-written corner sequences.
module tb_uart_rx_frontend;

`ifdef RX_MAJORITY_EN
    localparam int SH = 1;
`else
    localparam int SH = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_line = 1'b1;
    logic [31:0] clk_div = 32'd16;
    logic        rx_finish = 1'b0;
    logic [7:0]  rx_data;
    logic        irq;
    logic        rx_busy;
    logic        frame_err;

    uart_rx_frontend dut (
        .clk         (clk),
        .rst         (rst),
        .i_rx_line   (rx_line),
        .i_clk_div   (clk_div),
        .i_rx_finish (rx_finish),
        .o_rx_data   (rx_data),
        .o_irq       (irq),
        .o_rx_busy   (rx_busy),
        .o_frame_err (frame_err)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: irq events and status edges, sampled on the falling edge
    int         irq_cyc_q[$];
    logic [7:0] irq_data_q[$];
    logic [7:0] exp_q[$];
    int         busy_rise = -1;
    int         busy_fall = -1;
    int         err_rise = -1;
    logic       busy_prev = 1'b0;
    logic       err_prev = 1'b0;

    always @(negedge clk) begin
        if (irq === 1'b1) begin
            irq_cyc_q.push_back(cyc);
            irq_data_q.push_back(rx_data);
        end
        if (rx_busy && !busy_prev) busy_rise = cyc;
        if (!rx_busy && busy_prev) busy_fall = cyc;
        if (frame_err && !err_prev) err_rise = cyc;
        busy_prev = rx_busy;
        err_prev  = frame_err;
    end

    // scoreboard counters
    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // driver: caller is at a falling edge; returns the cycle the start bit was driven
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int d,
                              input logic [31:0] new_div, output int l);
        rx_line = 1'b0;
        l = cyc;
        repeat (d) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            if (k == 4 && new_div != 0) clk_div = new_div;
            rx_line = b[k];
            repeat (d) @(negedge clk);
        end
        rx_line = stop_bit;
        if (stop_bit) begin
            repeat (d) @(negedge clk);
        end else begin
            repeat (d / 2 + 1) @(negedge clk);
            rx_line = 1'b1;
            repeat (d - d / 2 - 1) @(negedge clk);
        end
        rx_line = 1'b1;
    endtask

    function automatic int done_cycle(input int l, input int cfg);
        int eff;
        eff = (cfg < 4) ? 4 : cfg;
        return l + 2 + eff / 2 + 9 * eff + 1 + SH;
    endfunction

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        logic [31:0] cfg;
        int          line_div;
        logic        exp_irq;
        logic [7:0]  exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int l, l2, done;

        vecs[0] = '{8'hA5, 1'b1, 32'd16, 16, 1'b1, 8'hA5, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 32'd16, 16, 1'b0, 8'hA5, 1'b1};
        vecs[2] = '{8'h81, 1'b1, 32'd2,  4,  1'b1, 8'h81, 1'b0};
        vecs[3] = '{8'hC3, 1'b1, 32'd5,  5,  1'b1, 8'hC3, 1'b0};

        // reset state
        repeat (3) @(negedge clk);
        check("reset rx_data", rx_data, 8'h00);
        check("reset irq", irq, 1'b0);
        check("reset busy", rx_busy, 1'b0);
        check("reset frame_err", frame_err, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // table-driven frames
        for (int i = 0; i < 4; i++) begin
            clk_div = vecs[i].cfg;
            irq_cyc_q.delete();
            irq_data_q.delete();
            repeat (3) @(negedge clk);
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].line_div, 32'd0, l);
            repeat (20) @(negedge clk);
            done = done_cycle(l, int'(vecs[i].cfg));
            check($sformatf("v%0d irq count", i), irq_cyc_q.size(), vecs[i].exp_irq ? 1 : 0);
            if (vecs[i].exp_irq && irq_cyc_q.size() > 0) begin
                check($sformatf("v%0d irq cycle", i), irq_cyc_q[0], done);
                check($sformatf("v%0d irq data", i), irq_data_q[0], vecs[i].exp_data);
            end
            check($sformatf("v%0d held data", i), rx_data, vecs[i].exp_data);
            check($sformatf("v%0d frame_err", i), frame_err, vecs[i].exp_err);
            check($sformatf("v%0d busy rise", i), busy_rise, l + 3);
            check($sformatf("v%0d busy fall", i), busy_fall, done);
            if (vecs[i].exp_err) begin
                check($sformatf("v%0d err rise", i), err_rise, done);
                rx_finish = 1'b1;
                @(negedge clk);
                rx_finish = 1'b0;
                check($sformatf("v%0d err cleared", i), frame_err, 1'b0);
                check($sformatf("v%0d data after clear", i), rx_data, vecs[i].exp_data);
            end
        end

        // back-to-back 0x00 then 0xFF, no idle gap
        clk_div = 32'd16;
        irq_cyc_q.delete();
        irq_data_q.delete();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1, 16, 32'd0, l);
        send_frame(8'hFF, 1'b1, 16, 32'd0, l2);
        repeat (20) @(negedge clk);
        check("b2b irq count", irq_cyc_q.size(), 2);
        if (irq_cyc_q.size() == 2) begin
            check("b2b spacing", irq_cyc_q[1] - irq_cyc_q[0], 160);
            check("b2b first cycle", irq_cyc_q[0], done_cycle(l, 16));
            for (int k = 0; k < 2; k++) begin
                check($sformatf("b2b data%0d", k), irq_data_q[k], exp_q.pop_front());
            end
        end

        // 4-cycle glitch -> false start, then a valid frame
        irq_cyc_q.delete();
        rx_line = 1'b0;
        l = cyc;
        repeat (4) @(negedge clk);
        rx_line = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch busy rise", busy_rise, l + 3);
        check("glitch busy fall", busy_fall, l + 2 + 9 + SH);
        check("glitch irq count", irq_cyc_q.size(), 0);
        check("glitch frame_err", frame_err, 1'b0);
        send_frame(8'h5A, 1'b1, 16, 32'd0, l);
        repeat (20) @(negedge clk);
        check("after glitch irq count", irq_cyc_q.size(), 1);
        check("after glitch data", rx_data, 8'h5A);

        // i_clk_div changed mid-frame is ignored
        irq_cyc_q.delete();
        send_frame(8'h96, 1'b1, 16, 32'd7, l);
        repeat (20) @(negedge clk);
        check("div change irq count", irq_cyc_q.size(), 1);
        if (irq_cyc_q.size() > 0) check("div change irq cycle", irq_cyc_q[0], done_cycle(l, 16));
        check("div change data", rx_data, 8'h96);
        clk_div = 32'd16;
        repeat (3) @(negedge clk);

        // reset during data bit 4 of 0xF0
        rx_line = 1'b0;
        repeat (80) @(negedge clk);
        rx_line = 1'b1;
        repeat (8) @(negedge clk);
        check("pre-reset busy", rx_busy, 1'b1);
        rst = 1'b1;
        #1;
        check("mid reset rx_data", rx_data, 8'h00);
        check("mid reset irq", irq, 1'b0);
        check("mid reset busy", rx_busy, 1'b0);
        check("mid reset frame_err", frame_err, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        irq_cyc_q.delete();
        irq_data_q.delete();
        repeat (100) @(negedge clk);
        check("post-reset no irq", irq_cyc_q.size(), 0);
        send_frame(8'h12, 1'b1, 16, 32'd0, l);
        repeat (20) @(negedge clk);
        check("post-reset irq count", irq_cyc_q.size(), 1);
        if (irq_cyc_q.size() > 0) check("post-reset irq cycle", irq_cyc_q[0], done_cycle(l, 16));
        check("post-reset data", rx_data, 8'h12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
